ins_fetch_unit: RTL and testbench
=================================

Name: ins_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction ROM and also consumes its output.
- Owns the program counter and drives the ROM address.
- Waits out the ROM's two-cycle registered latency and checks the returned address tag.
- Assembles 1- or 2-word instructions, splits them into fields and hands them to the execute stage over a valid/ready handshake; a branch input redirects the counter.

Parameters:
- RESET_PC, 16'h0000, address of the first fetch after reset.
- ROM_LAT, 2, cycles from rom_addr change to matching rom_addr_in/rom_data_in (minimum 1).

Ports:
- clk  in  1  rising-edge clock; the block's single clock.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  16  address to ROM (ROM_addr); registered.
- rom_addr_in  in  16  address tag returned by ROM (ROM_addr_out).
- rom_data_in  in  16  instruction word from ROM (ROM_InsSet_out).
- branch_en  in  1  redirect request, one cycle.
- branch_target  in  16  redirect address.
- dec_valid  out  1  decoded instruction available.
- dec_ready  in  1  execute stage accepts.
- dec_pc  out  16  address of the instruction's first word.
- dec_mode  out  2  word1[15:14].
- dec_two_word  out  1  1 when word1[13:12]==2'b10.
- dec_opcode  out  4  word1[11:8].
- dec_op1  out  3  word1[7:5].
- dec_op2  out  3  word1[4:2].
- dec_optype  out  2  word1[1:0].
- dec_imm  out  16  second word; 0 for 1-word instructions.
- dec_illegal  out  1  word1[13:12]==2'b11.

Behaviour:
- States: F1 (wait for word 1), F2 (wait for word 2), HOLD (dec_valid=1).
- Reset: pc=RESET_PC, rom_addr=RESET_PC, state=F1, wait_cnt=0. dec_valid=0 and every dec_* output is 0.
- wait_cnt: cleared whenever rom_addr is loaded; increments (saturating) otherwise.
- capture = (wait_cnt >= ROM_LAT) && (rom_addr_in == rom_addr).
  - A tag mismatch keeps waiting, so stale ROM contents after reset or a redirect are never used.
- F1 with capture:
  - Latch the fields of rom_data_in.
  - Byte field 10: rom_addr <= pc+1, go to F2.
  - Otherwise (00, 01, 11): dec_imm=0, go to HOLD. Byte field 11 also sets dec_illegal and is treated as 1 word.
- F2 with capture: dec_imm <= rom_data_in, go to HOLD.
- HOLD:
  - dec_valid=1 and all dec_* outputs are stable until dec_valid && dec_ready.
  - On that handshake: pc <= pc + (dec_two_word ? 2 : 1), rom_addr <= new pc, dec_valid <= 0, go to F1.
- Latency with ROM_LAT=2:
  - Address visible at cycle 0 → capture edge ends cycle 2 → dec_valid at cycle 3 (1 word).
  - For 2 words, dec_valid rises at cycle 6.
  - dec_ready held high gives one 1-word instruction per 4 cycles.
- Arithmetic: pc is 16-bit modulo.
  - FFFF+1 → 0000, so a 2-word instruction at FFFF takes its immediate from 0000.
  - A 2-word instruction at FFFF advances pc to 0001.
- Branch (any state):
  - pc <= branch_target, rom_addr <= branch_target, wait_cnt <= 0, state <= F1, dec_valid <= 0 next cycle.
  - Any partial F2 assembly is dropped.
- Branch and handshake in the same cycle: the transfer counts as completed, and the branch target wins for the next pc.
- rst has priority over branch_en and the handshake; reset in mid-assembly discards everything.
- No combinational path from any input to any output.

Test Plan:
- Reset, ROM model (2-cycle latency) with mem[0]=16'b0001101101011100:
  - rom_addr=0000; dec_valid rises at cycle 3.
  - dec_mode=00, dec_two_word=0, opcode=1011, op1=010, op2=111, optype=00, imm=0, dec_pc=0000.
- mem[3]=16'b1010110111001100, mem[4]=16'h8449, branch to 0003:
  - rom_addr shows 0003 then 0004.
  - dec_two_word=1, opcode=1101, op1=110, op2=011, dec_imm=8449, dec_pc=0003.
  - After the handshake rom_addr=0005.
- dec_ready low for 5 cycles while dec_valid=1 (mem[5]=16'b0001000000010101):
  - Outputs hold opcode=0000, op1=000, op2=101, optype=01.
  - rom_addr stays 0005; it advances to 0006 only after dec_ready=1.
- ROM model returns a wrong tag (rom_addr_in=1234) for 3 extra cycles: no capture and dec_valid stays 0 until the tag equals rom_addr.
- branch_en to 0020 while in F2 of a 2-word fetch: the partial instruction is dropped, and the next dec_pc is 0020.
- 2-word instruction at FFFF (word1[13:12]=10, mem[0000]=ABCD):
  - dec_imm=ABCD and rom_addr=0001 after the handshake.
- Word1 with byte field 11: dec_illegal=1, dec_two_word=0, pc advances by 1.

Source files
------------

// File: rtl/ins_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM and waits out its latency.
// Assembles 1- or 2-word instructions and hands out decoded fields over valid/ready.
module ins_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ROM_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_addr_in,
  input  logic [15:0] rom_data_in,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_pc,
  output logic [1:0]  dec_mode,
  output logic        dec_two_word,
  output logic [3:0]  dec_opcode,
  output logic [2:0]  dec_op1,
  output logic [2:0]  dec_op2,
  output logic [1:0]  dec_optype,
  output logic [15:0] dec_imm,
  output logic        dec_illegal
);

  localparam int CW = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(ROM_LAT);

  typedef enum logic [1:0] {F1, F2, HOLD} state_e;

  state_e        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   rom_addr_q, rom_addr_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          valid_q, valid_d;
  logic [15:0]   dpc_q, dpc_d;
  logic [1:0]    mode_q, mode_d;
  logic          two_q, two_d;
  logic [3:0]    opc_q, opc_d;
  logic [2:0]    op1_q, op1_d;
  logic [2:0]    op2_q, op2_d;
  logic [1:0]    otype_q, otype_d;
  logic [15:0]   imm_q, imm_d;
  logic          ill_q, ill_d;

  logic          capture;
  logic          hs;
  logic [15:0]   pc_next;

  assign capture = (wait_cnt_q >= LAT) && (rom_addr_in == rom_addr_q);
  assign hs      = valid_q && dec_ready;
  assign pc_next = pc_q + (two_q ? 16'd2 : 16'd1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rom_addr_d = rom_addr_q;
    wait_cnt_d = (wait_cnt_q == LAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    valid_d    = valid_q;
    dpc_d      = dpc_q;
    mode_d     = mode_q;
    two_d      = two_q;
    opc_d      = opc_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    otype_d    = otype_q;
    imm_d      = imm_q;
    ill_d      = ill_q;

    unique case (state_q)
      F1: begin
        if (capture) begin
          dpc_d   = pc_q;
          mode_d  = rom_data_in[15:14];
          two_d   = rom_data_in[13:12] == 2'b10;
          ill_d   = rom_data_in[13:12] == 2'b11;
          opc_d   = rom_data_in[11:8];
          op1_d   = rom_data_in[7:5];
          op2_d   = rom_data_in[4:2];
          otype_d = rom_data_in[1:0];
          if (rom_data_in[13:12] == 2'b10) begin
            rom_addr_d = pc_q + 16'd1;
            wait_cnt_d = '0;
            state_d    = F2;
          end else begin
            imm_d   = 16'h0000;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      F2: begin
        if (capture) begin
          imm_d   = rom_data_in;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hs) begin
          pc_d       = pc_next;
          rom_addr_d = pc_next;
          wait_cnt_d = '0;
          valid_d    = 1'b0;
          state_d    = F1;
        end
      end
      default: state_d = F1;
    endcase

    // A redirect overrides any in-flight assembly or completed transfer.
    if (branch_en) begin
      pc_d       = branch_target;
      rom_addr_d = branch_target;
      wait_cnt_d = '0;
      valid_d    = 1'b0;
      state_d    = F1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= F1;
      pc_q       <= RESET_PC;
      rom_addr_q <= RESET_PC;
      wait_cnt_q <= '0;
      valid_q    <= 1'b0;
      dpc_q      <= '0;
      mode_q     <= '0;
      two_q      <= 1'b0;
      opc_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      otype_q    <= '0;
      imm_q      <= '0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      wait_cnt_q <= wait_cnt_d;
      valid_q    <= valid_d;
      dpc_q      <= dpc_d;
      mode_q     <= mode_d;
      two_q      <= two_d;
      opc_q      <= opc_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      otype_q    <= otype_d;
      imm_q      <= imm_d;
      ill_q      <= ill_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign dec_valid    = valid_q;
  assign dec_pc       = dpc_q;
  assign dec_mode     = mode_q;
  assign dec_two_word = two_q;
  assign dec_opcode   = opc_q;
  assign dec_op1      = op1_q;
  assign dec_op2      = op2_q;
  assign dec_optype   = otype_q;
  assign dec_imm      = imm_q;
  assign dec_illegal  = ill_q;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: 2-cycle ROM model, directed steps,
// expected instructions queued at stimulus time and popped on dec_valid.
module tb_ins_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr, rom_addr_in, rom_data_in;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        dec_valid, dec_ready;
  logic [15:0] dec_pc, dec_imm;
  logic [1:0]  dec_mode, dec_optype;
  logic        dec_two_word, dec_illegal;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_op1, dec_op2;

  always #5 clk = ~clk;

  ins_fetch_unit dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_addr_in(rom_addr_in),
    .rom_data_in(rom_data_in),
    .branch_en(branch_en), .branch_target(branch_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_mode(dec_mode),
    .dec_two_word(dec_two_word), .dec_opcode(dec_opcode),
    .dec_op1(dec_op1), .dec_op2(dec_op2),
    .dec_optype(dec_optype), .dec_imm(dec_imm),
    .dec_illegal(dec_illegal)
  );

  // ROM model: two registered stages, tag can be forced wrong
  logic [15:0] mem [0:65535];
  logic [15:0] a1, a2, d1, d2;
  logic        bad;
  always @(posedge clk) begin
    a1 <= rom_addr;
    d1 <= mem[rom_addr];
    a2 <= a1;
    d2 <= d1;
  end
  assign rom_addr_in = bad ? 16'h1234 : a2;
  assign rom_data_in = d2;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  mode;
    logic        two;
    logic [3:0]  opc;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic [1:0]  ot;
    logic [15:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t e5;
  int total = 0;
  int passed = 0;
  int fails = 0;

  function automatic exp_t mk(input logic [15:0] pc, input logic [1:0] mode,
                              input logic two, input logic [3:0] opc,
                              input logic [2:0] op1, input logic [2:0] op2,
                              input logic [1:0] ot, input logic [15:0] imm,
                              input logic ill);
    exp_t e;
    e.pc = pc; e.mode = mode; e.two = two; e.opc = opc;
    e.op1 = op1; e.op2 = op2; e.ot = ot; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t obs_now();
    exp_t o;
    o = {dec_pc, dec_mode, dec_two_word, dec_opcode,
         dec_op1, dec_op2, dec_optype, dec_imm, dec_illegal};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (dec_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 48'(dec_valid), 48'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    wait_valid(tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 48'd0, 48'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, obs_now(), e);
    end
  endtask

  task automatic handshake();
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask

  task automatic branch(input logic [15:0] t);
    branch_en = 1'b1;
    branch_target = t;
    @(negedge clk);
    branch_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dec_ready = 1'b0;
    branch_en = 1'b0;
    branch_target = 16'h0;
    bad = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1B5C;
    mem[16'h0001] = 16'h368E;
    mem[16'h0003] = 16'hADCC;
    mem[16'h0004] = 16'h8449;
    mem[16'h0005] = 16'h1015;
    mem[16'h0007] = 16'h2000;
    mem[16'h0008] = 16'h1111;
    mem[16'h0020] = 16'h4326;
    mem[16'hFFFF] = 16'hE5A7;

    repeat (3) @(negedge clk);
    chk("rst_addr", 48'(rom_addr), 48'h0);
    chk("rst_valid", 48'(dec_valid), 48'd0);
    chk("rst_fields", obs_now(), 48'd0);

    // 1-word at 0000: dec_valid at cycle 3
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat1_c2", 48'(dec_valid), 48'd0);
    @(negedge clk);
    chk("lat1_c3", 48'(dec_valid), 48'd1);
    sb.push_back(mk(16'h0000, 2'b00, 1'b0, 4'b1011, 3'b010, 3'b111,
                    2'b00, 16'h0000, 1'b0));
    pop_check("i0000");
    handshake();
    chk("hs0_addr", 48'(rom_addr), 48'h0001);
    chk("hs0_valid", 48'(dec_valid), 48'd0);

    // branch to 0003: 2-word, valid at cycle 6
    branch(16'h0003);
    chk("br3_addr", 48'(rom_addr), 48'h0003);
    repeat (3) @(negedge clk);
    chk("w2_addr", 48'(rom_addr), 48'h0004);
    chk("w2_c3_valid", 48'(dec_valid), 48'd0);
    repeat (3) @(negedge clk);
    chk("lat2_c6", 48'(dec_valid), 48'd1);
    sb.push_back(mk(16'h0003, 2'b10, 1'b1, 4'b1101, 3'b110, 3'b011,
                    2'b00, 16'h8449, 1'b0));
    pop_check("i0003");
    handshake();
    chk("hs3_addr", 48'(rom_addr), 48'h0005);

    // stall with dec_ready low
    e5 = mk(16'h0005, 2'b00, 1'b0, 4'b0000, 3'b000, 3'b101,
            2'b01, 16'h0000, 1'b0);
    sb.push_back(e5);
    pop_check("i0005");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_fields", obs_now(), e5);
      chk("hold_addr", 48'(rom_addr), 48'h0005);
    end
    bad = 1'b1;
    handshake();
    chk("hs5_addr", 48'(rom_addr), 48'h0006);

    // wrong tag for 3 cycles beyond normal capture
    for (int i = 0; i < 6; i++) begin
      chk("badtag_valid", 48'(dec_valid), 48'd0);
      if (i == 5) bad = 1'b0;
      @(negedge clk);
    end
    chk("badtag_c6", 48'(dec_valid), 48'd1);
    sb.push_back(mk(16'h0006, 2'b00, 1'b0, 4'h0, 3'h0, 3'h0,
                    2'b00, 16'h0000, 1'b0));
    pop_check("i0006");
    handshake();
    chk("hs6_addr", 48'(rom_addr), 48'h0007);

    // branch while in F2 of a 2-word fetch
    repeat (3) @(negedge clk);
    chk("f2_addr", 48'(rom_addr), 48'h0008);
    branch(16'h0020);
    chk("br20_addr", 48'(rom_addr), 48'h0020);
    chk("br20_valid", 48'(dec_valid), 48'd0);
    sb.push_back(mk(16'h0020, 2'b01, 1'b0, 4'b0011, 3'b001, 3'b001,
                    2'b10, 16'h0000, 1'b0));
    pop_check("i0020");
    handshake();

    // 2-word at FFFF wraps to 0000 for its immediate
    branch(16'hFFFF);
    mem[16'h0000] = 16'hABCD;
    sb.push_back(mk(16'hFFFF, 2'b11, 1'b1, 4'b0101, 3'b101, 3'b001,
                    2'b11, 16'hABCD, 1'b0));
    pop_check("iFFFF");
    handshake();
    chk("wrap_addr", 48'(rom_addr), 48'h0001);

    // byte field 11: illegal, treated as 1 word
    sb.push_back(mk(16'h0001, 2'b00, 1'b0, 4'b0110, 3'b100, 3'b011,
                    2'b10, 16'h0000, 1'b1));
    pop_check("ill0001");
    handshake();
    chk("ill_addr", 48'(rom_addr), 48'h0002);

    // branch and handshake together: target wins
    sb.push_back(mk(16'h0002, 2'b00, 1'b0, 4'h0, 3'h0, 3'h0,
                    2'b00, 16'h0000, 1'b0));
    pop_check("i0002");
    dec_ready = 1'b1;
    branch(16'h0040);
    dec_ready = 1'b0;
    chk("brhs_addr", 48'(rom_addr), 48'h0040);
    chk("brhs_valid", 48'(dec_valid), 48'd0);
    sb.push_back(mk(16'h0040, 2'b00, 1'b0, 4'h0, 3'h0, 3'h0,
                    2'b00, 16'h0000, 1'b0));
    pop_check("i0040");
    handshake();
    chk("hs40_addr", 48'(rom_addr), 48'h0041);

    // reset during F2 discards the partial instruction
    branch(16'h0003);
    repeat (3) @(negedge clk);
    chk("rst_f2_addr", 48'(rom_addr), 48'h0004);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_addr", 48'(rom_addr), 48'h0000);
    chk("mrst_valid", 48'(dec_valid), 48'd0);
    chk("mrst_fields", obs_now(), 48'd0);
    sb.push_back(mk(16'h0000, 2'b10, 1'b1, 4'b1011, 3'b110, 3'b011,
                    2'b01, 16'h368E, 1'b0));
    pop_check("post_rst");
    chk("sb_drained", 48'(sb.size()), 48'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
